pipelined_decoder: RTL and testbench
====================================

Name: pipelined_decoder

Overview:
- Registered, handshaked successor to the single-cycle opcode decoder.
- Sits between the fetch register and the execute/register-file stage.
- Decodes one instruction per accepted handshake into registered control signals.
- Stalls fetch during multi-cycle multiplies and while STIN waits for an input strobe.
- Width of the opcode, ALU function field and multiply latency are parameters.

Parameters:
- OP_W, 6, opcode width; must be >= FUNC_W+3.
- FUNC_W, 3, ALU function field width, taken from opcode[FUNC_W-1:0].
- MUL_FUNC, 3'b010, function code that denotes multiply.
- MUL_LAT, 3, execute cycles a multiply occupies; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decoder accepts instruction this cycle
- opcode  in  OP_W  instruction opcode
- zf  in  1  zero flag from ALU, sampled at acceptance
- io_strobe  in  1  external input data valid
- out_valid  out  1  registered controls valid for exactly one cycle
- alu_func  out  FUNC_W  registered ALU function
- reg_write  out  1  registered write enable
- immediate  out  1  registered immediate select
- pc_rel_branch  out  1  registered branch-taken
- read_in  out  1  registered input-load select
- write_out  out  1  registered output-store select
- illegal  out  1  registered illegal-opcode flag

Behaviour:
- Class field cls = opcode[OP_W-1:OP_W-3]. The encodings are decided as follows:
  - 000 reg ALU: reg_write.
  - 001 imm ALU: reg_write, immediate.
  - 010 BEQ: pc_rel_branch = zf.
  - 011 JMP: pc_rel_branch = 1.
  - 100 STIN: reg_write, read_in.
  - 101 LOUT: write_out.
  - 110 NOP: no control asserted.
  - 111 reserved: illegal = 1, other controls 0.
- alu_func = opcode[FUNC_W-1:0] for every class.
- Reset: state IDLE, all outputs 0, counter 0. Reset may assert in any state, including mid-multiply or mid-STIN wait, and returns immediately to IDLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, register the decoded controls and assert out_valid next cycle (1-cycle latency). Then branch on the instruction:
    - Multiply (cls 000 or 001 with func == MUL_FUNC) and MUL_LAT > 1: go to MUL_WAIT with counter = MUL_LAT-1.
    - STIN: go to IN_WAIT and hold out_valid = 0.
    - Otherwise: stay in IDLE.
  - MUL_WAIT: in_ready = 0 and out_valid = 0 after the first cycle. Counter decrements each cycle; at 1, return to IDLE.
  - IN_WAIT: in_ready = 0 and out_valid = 0. On io_strobe, assert out_valid for one cycle with the registered STIN controls, then return to IDLE.
- If io_strobe is already high in the acceptance cycle, it is ignored; STIN waits for a strobe sampled in IN_WAIT.
- When out_valid = 0, all control outputs read 0; alu_func holds its last value.
- zf is sampled only at acceptance. Later changes do not alter pc_rel_branch.
- No input buffering: in_valid while in_ready = 0 is ignored. Fetch must hold the instruction until it is accepted.
- Back-to-back non-multiply, non-STIN instructions sustain one per cycle.

Optional Feature:
- Macro: DECODER_BNE_EN.
- Defined: cls 111 decodes as BNE, with pc_rel_branch = ~zf and illegal = 0.
- Undefined: cls 111 sets illegal = 1 with all other controls 0.

Test Plan:
- Reset mid-stream (rst pulsed while in MUL_WAIT) -> next cycle all outputs 0, in_ready = 1.
- ADD opcode 000001 then ADDI opcode 001001 back-to-back ->
  - Cycle 1: out_valid, reg_write = 1, immediate = 0, alu_func = 001.
  - Cycle 2: immediate = 1.
  - in_ready stays 1 throughout.
- MLT opcode 000010 with MUL_LAT = 3 -> out_valid one cycle later, then in_ready low for 2 cycles, then high; a second instruction held on in_valid is accepted on the third cycle.
- BEQ opcode 010000:
  - zf = 1 -> pc_rel_branch = 1.
  - zf = 0 -> pc_rel_branch = 0.
  - zf toggled after acceptance -> output unchanged.
- STIN opcode 100000, io_strobe asserted 4 cycles after acceptance -> in_ready low for those 4 cycles; out_valid with reg_write = 1 and read_in = 1 on the cycle after the strobe.
- Opcode 111000 ->
  - Without DECODER_BNE_EN: illegal = 1, other controls 0.
  - With DECODER_BNE_EN and zf = 0: pc_rel_branch = 1, illegal = 0.

Source files
------------

// File: rtl/pipelined_decoder.sv
// -----------------------------------------------------------------------------
// pipelined_decoder
//
// Registered, handshaked opcode decoder that sits between the fetch register
// and the execute/register-file stage. One instruction is decoded per accepted
// handshake. Fetch is stalled while a multi-cycle multiply occupies execute
// and while an input-load (STIN) waits for the external input strobe.
//
// Handshake: an instruction is accepted on a rising clk edge where
// in_valid && in_ready. There is no input buffering; fetch must hold the
// instruction stable until it is accepted. out_valid is a one-cycle pulse
// per decoded instruction and has no backpressure.
//
// Configuration macro: DECODER_BNE_EN
//   defined   -> class 111 decodes as BNE (pc_rel_branch = ~zf)
//   undefined -> class 111 is reserved and raises illegal
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready instruction handshake from fetch
//   opcode            instruction opcode (OP_W bits)
//   zf                ALU zero flag, sampled only at acceptance
//   io_strobe         external input data valid (completes STIN)
//   out_valid         one-cycle pulse: control outputs are meaningful
//   alu_func          registered ALU function (holds when out_valid = 0)
//   reg_write, immediate, pc_rel_branch, read_in, write_out, illegal
//                     registered controls, forced to 0 when out_valid = 0
//   dbg_state         current FSM state (0 IDLE, 1 MUL_WAIT, 2 IN_WAIT)
// -----------------------------------------------------------------------------
module pipelined_decoder #(
  parameter int unsigned OP_W     = 6,
  parameter int unsigned FUNC_W   = 3,
  parameter logic [FUNC_W-1:0] MUL_FUNC = FUNC_W'(3'b010),
  parameter int unsigned MUL_LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic              zf,
  input  logic              io_strobe,
  output logic              out_valid,
  output logic [FUNC_W-1:0] alu_func,
  output logic              reg_write,
  output logic              immediate,
  output logic              pc_rel_branch,
  output logic              read_in,
  output logic              write_out,
  output logic              illegal,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_IN_WAIT  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic [FUNC_W-1:0] alu_func_q, alu_func_d;
  logic reg_write_q, reg_write_d;
  logic immediate_q, immediate_d;
  logic branch_q, branch_d;
  logic read_in_q, read_in_d;
  logic write_out_q, write_out_d;
  logic illegal_q, illegal_d;

  // Combinational decode of the presented opcode
  logic [2:0] cls;
  logic [FUNC_W-1:0] func;
  logic dec_reg_write, dec_immediate, dec_branch;
  logic dec_read_in, dec_write_out, dec_illegal;
  logic is_mul, is_stin, accept;

  assign cls    = opcode[OP_W-1 -: 3];
  assign func   = opcode[FUNC_W-1:0];
  assign accept = (state_q == ST_IDLE) && in_valid;

  always_comb begin
    dec_reg_write = 1'b0;
    dec_immediate = 1'b0;
    dec_branch    = 1'b0;
    dec_read_in   = 1'b0;
    dec_write_out = 1'b0;
    dec_illegal   = 1'b0;
    case (cls)
      3'b000: dec_reg_write = 1'b1;
      3'b001: begin
        dec_reg_write = 1'b1;
        dec_immediate = 1'b1;
      end
      3'b010: dec_branch = zf;
      3'b011: dec_branch = 1'b1;
      3'b100: begin
        dec_reg_write = 1'b1;
        dec_read_in   = 1'b1;
      end
      3'b101: dec_write_out = 1'b1;
      3'b110: ;
      default: begin
`ifdef DECODER_BNE_EN
        dec_branch = ~zf;
`else
        dec_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign is_mul  = ((cls == 3'b000) || (cls == 3'b001)) && (func == MUL_FUNC);
  assign is_stin = (cls == 3'b100);

  // State register and registered controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      out_valid_q <= 1'b0;
      alu_func_q  <= '0;
      reg_write_q <= 1'b0;
      immediate_q <= 1'b0;
      branch_q    <= 1'b0;
      read_in_q   <= 1'b0;
      write_out_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      alu_func_q  <= alu_func_d;
      reg_write_q <= reg_write_d;
      immediate_q <= immediate_d;
      branch_q    <= branch_d;
      read_in_q   <= read_in_d;
      write_out_q <= write_out_d;
      illegal_q   <= illegal_d;
    end
  end

  // Next-state, counter and out_valid pulse
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_stin) begin
            // STIN results are released only after the strobe arrives
            state_d = ST_IN_WAIT;
          end else begin
            out_valid_d = 1'b1;
            if (is_mul && (MUL_LAT > 1)) begin
              state_d = ST_MUL_WAIT;
              cnt_d   = 4'(MUL_LAT - 1);
            end
          end
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_IN_WAIT: begin
        if (io_strobe) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Controls are captured only at acceptance and held otherwise, so a late
  // zf change or a STIN wait cannot disturb them.
  always_comb begin
    alu_func_d  = alu_func_q;
    reg_write_d = reg_write_q;
    immediate_d = immediate_q;
    branch_d    = branch_q;
    read_in_d   = read_in_q;
    write_out_d = write_out_q;
    illegal_d   = illegal_q;
    if (accept) begin
      alu_func_d  = func;
      reg_write_d = dec_reg_write;
      immediate_d = dec_immediate;
      branch_d    = dec_branch;
      read_in_d   = dec_read_in;
      write_out_d = dec_write_out;
      illegal_d   = dec_illegal;
    end
  end

  // Outputs: controls are masked outside the out_valid pulse
  always_comb begin
    in_ready      = (state_q == ST_IDLE);
    out_valid     = out_valid_q;
    alu_func      = alu_func_q;
    reg_write     = out_valid_q & reg_write_q;
    immediate     = out_valid_q & immediate_q;
    pc_rel_branch = out_valid_q & branch_q;
    read_in       = out_valid_q & read_in_q;
    write_out     = out_valid_q & write_out_q;
    illegal       = out_valid_q & illegal_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_pipelined_decoder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_decoder
//
// Directed testbench for pipelined_decoder (default parameters, MUL_LAT = 3).
// Inputs change 1 ns after a rising edge; outputs are checked at that same
// point, i.e. they reflect the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_pipelined_decoder;

  localparam int OP_W   = 6;
  localparam int FUNC_W = 3;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opcode;
  logic              zf;
  logic              io_strobe;
  logic              out_valid;
  logic [FUNC_W-1:0] alu_func;
  logic              reg_write;
  logic              immediate;
  logic              pc_rel_branch;
  logic              read_in;
  logic              write_out;
  logic              illegal;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;

  pipelined_decoder #(
    .OP_W    (OP_W),
    .FUNC_W  (FUNC_W),
    .MUL_FUNC(3'b010),
    .MUL_LAT (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .zf           (zf),
    .io_strobe    (io_strobe),
    .out_valid    (out_valid),
    .alu_func     (alu_func),
    .reg_write    (reg_write),
    .immediate    (immediate),
    .pc_rel_branch(pc_rel_branch),
    .read_in      (read_in),
    .write_out    (write_out),
    .illegal      (illegal),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [OP_W-1:0] op, input logic z);
    in_valid = 1'b1;
    opcode   = op;
    zf       = z;
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] exp_ctrl);
    // order: reg_write, immediate, pc_rel_branch, read_in, write_out, illegal
    check(tag, {26'd0, reg_write, immediate, pc_rel_branch, read_in, write_out, illegal},
          {26'd0, exp_ctrl});
  endtask

  logic exp_bne_branch;
  logic exp_bne_illegal;

  initial begin
`ifdef DECODER_BNE_EN
    exp_bne_branch  = 1'b1;
    exp_bne_illegal = 1'b0;
`else
    exp_bne_branch  = 1'b0;
    exp_bne_illegal = 1'b1;
`endif
    rst = 1'b1; in_valid = 1'b0; opcode = '0; zf = 1'b0; io_strobe = 1'b0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_func", alu_func, 0);
    check_ctrl("rst_ctrl", 6'b000000);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    step();

    // ADD then ADDI back-to-back
    present(6'b000001, 1'b0);
    check("add_in_ready", in_ready, 1);
    step();
    check("add_out_valid", out_valid, 1);
    check("add_alu_func", alu_func, 3'b001);
    check_ctrl("add_ctrl", 6'b100000);
    check("add_in_ready2", in_ready, 1);
    present(6'b001001, 1'b0);
    step();
    check("addi_out_valid", out_valid, 1);
    check_ctrl("addi_ctrl", 6'b110000);
    check("addi_in_ready", in_ready, 1);
    in_valid = 1'b0;
    step();
    check("idle_out_valid", out_valid, 0);
    check_ctrl("idle_ctrl_masked", 6'b000000);
    check("idle_alu_func_hold", alu_func, 3'b001);

    // MLT with MUL_LAT = 3, next instruction held on in_valid
    present(6'b000010, 1'b0);
    step();
    check("mul_out_valid", out_valid, 1);
    check("mul_alu_func", alu_func, 3'b010);
    check_ctrl("mul_ctrl", 6'b100000);
    check("mul_in_ready_c1", in_ready, 0);
    check("mul_state", dbg_state, 1);
    present(6'b000011, 1'b0);
    step();
    check("mul_in_ready_c2", in_ready, 0);
    check("mul_out_valid_c2", out_valid, 0);
    step();
    check("mul_in_ready_c3", in_ready, 1);
    check("mul_out_valid_c3", out_valid, 0);
    step();
    check("held_out_valid", out_valid, 1);
    check("held_alu_func", alu_func, 3'b011);
    in_valid = 1'b0;
    step();
    check("held_single_pulse", out_valid, 0);

    // BEQ with zf = 1, zf toggled right after acceptance
    present(6'b010000, 1'b1);
    step();
    in_valid = 1'b0; zf = 1'b0;
    check("beq_z1_valid", out_valid, 1);
    check_ctrl("beq_z1_ctrl", 6'b001000);
    // BEQ with zf = 0, zf toggled right after acceptance
    present(6'b010000, 1'b0);
    step();
    in_valid = 1'b0; zf = 1'b1;
    check("beq_z0_valid", out_valid, 1);
    check_ctrl("beq_z0_ctrl", 6'b000000);
    step();

    // STIN: strobe high at acceptance is ignored, real strobe 4 cycles later
    present(6'b100000, 1'b0);
    io_strobe = 1'b1;
    step();
    in_valid = 1'b0; io_strobe = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("stin_in_ready_c%0d", i), in_ready, 0);
      check($sformatf("stin_out_valid_c%0d", i), out_valid, 0);
      check_ctrl($sformatf("stin_ctrl_c%0d", i), 6'b000000);
      if (i == 4) io_strobe = 1'b1;
      step();
    end
    io_strobe = 1'b0;
    check("stin_out_valid", out_valid, 1);
    check_ctrl("stin_ctrl", 6'b100100);
    check("stin_in_ready", in_ready, 1);
    step();
    check("stin_pulse_end", out_valid, 0);
    check("stin_state_idle", dbg_state, 0);

    // LOUT, JMP, NOP back-to-back
    present(6'b101000, 1'b0);
    step();
    check_ctrl("lout_ctrl", 6'b000010);
    present(6'b011000, 1'b0);
    step();
    check_ctrl("jmp_ctrl", 6'b001000);
    present(6'b110000, 1'b1);
    step();
    check("nop_out_valid", out_valid, 1);
    check_ctrl("nop_ctrl", 6'b000000);
    in_valid = 1'b0;

    // Class 111 with zf = 0
    present(6'b111000, 1'b0);
    step();
    in_valid = 1'b0;
    check("cls7_out_valid", out_valid, 1);
    check_ctrl("cls7_ctrl", {2'b00, exp_bne_branch, 2'b00, exp_bne_illegal});
    step();

    // Reset asserted mid-multiply (ADDI-class multiply)
    present(6'b001010, 1'b0);
    step();
    in_valid = 1'b0;
    check("rmul_in_ready", in_ready, 0);
    check_ctrl("rmul_ctrl", 6'b110000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmul_out_valid", out_valid, 0);
    check("rmul_in_ready_after", in_ready, 1);
    check("rmul_alu_func", alu_func, 0);
    check_ctrl("rmul_ctrl_after", 6'b000000);
    check("rmul_state", dbg_state, 0);
    present(6'b000101, 1'b0);
    step();
    in_valid = 1'b0;
    check("post_rst_out_valid", out_valid, 1);
    check("post_rst_alu_func", alu_func, 3'b101);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
